// File: rtl/lab_digitize_sched.sv
// lab_digitize_sched
//   Shares one LAB Wilkinson ADC sequencer between NREQ buffer requesters.
//   Each granted requester gets one exclusive transaction:
//     START -> CONVERT (wait adc_done_i, watchdog) -> READOUT (wait rd_done_i)
//     -> RELEASE (read_done_o) -> ACK (ack_o)
//   Grants rotate round-robin starting from the index after the last owner.
//   A conversion that never completes is aborted by the watchdog; the
//   requester is still acked and can inspect timeout_o.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   enable_i            allows new grants in IDLE
//   req_i[NREQ]         level requests, held until ack
//   ack_o[NREQ]         one-cycle one-hot completion pulse
//   grant_o[NREQ]       one-hot owner of the current transaction
//   busy_o              transaction in flight
//   adc_start_o         start pulse to the ADC sequencer
//   adc_done_i          conversion-done pulse from the ADC sequencer
//   read_done_o         ramp release pulse to the ADC sequencer
//   rd_start_o          readout launch pulse
//   rd_buf_o            buffer index for the readout
//   rd_done_i           readout-complete pulse
//   timeout_o           sticky watchdog flag, cleared by timeout_clr_i
//   conv_count_o        successful conversions, wraps at 16 bits
module lab_digitize_sched #(
  parameter int NREQ    = 4,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 8192
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic [NREQ-1:0]   req_i,
  output logic [NREQ-1:0]   ack_o,
  output logic [NREQ-1:0]   grant_o,
  output logic              busy_o,
  output logic              adc_start_o,
  input  logic              adc_done_i,
  output logic              read_done_o,
  output logic              rd_start_o,
  output logic [IDX_W-1:0]  rd_buf_o,
  input  logic              rd_done_i,
  output logic              timeout_o,
  input  logic              timeout_clr_i,
  output logic [15:0]       conv_count_o
);

  typedef enum logic [2:0] {
    IDLE, START, CONVERT, READOUT, RELEASE, ACK
  } state_t;

  localparam logic [IDX_W:0]   NREQ_X   = (IDX_W+1)'(NREQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);
  localparam logic [NREQ-1:0]  ONE      = NREQ'(1);
  localparam logic [15:0]      TO_LAST  = 16'(TIMEOUT - 1);

  state_t            state;
  logic [IDX_W-1:0]  ptr;
  logic [15:0]       wdog;

  // Round-robin pick: first requester at or after ptr, wrapping.
  // Scanning offsets high-to-low lets the smallest offset win last.
  logic              pick_vld;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W:0]    sum;

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    sum      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= NREQ_X) sum = sum - NREQ_X;
      if (req_i[sum[IDX_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = sum[IDX_W-1:0];
      end
    end
  end

  // Outputs are registered: each pulse is set on the edge entering the
  // state in which it must be visible, so it is high for exactly that state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      ptr          <= '0;
      wdog         <= '0;
      ack_o        <= '0;
      grant_o      <= '0;
      busy_o       <= 1'b0;
      adc_start_o  <= 1'b0;
      read_done_o  <= 1'b0;
      rd_start_o   <= 1'b0;
      rd_buf_o     <= '0;
      timeout_o    <= 1'b0;
      conv_count_o <= '0;
    end else begin
      adc_start_o <= 1'b0;
      rd_start_o  <= 1'b0;
      read_done_o <= 1'b0;
      ack_o       <= '0;
      // A watchdog set later in this block overrides the clear.
      if (timeout_clr_i) timeout_o <= 1'b0;

      case (state)
        IDLE: begin
          if (enable_i && pick_vld) begin
            grant_o     <= ONE << pick_idx;
            rd_buf_o    <= pick_idx;
            adc_start_o <= 1'b1;
            busy_o      <= 1'b1;
            state       <= START;
          end
        end
        START: begin
          wdog  <= '0;
          state <= CONVERT;
        end
        CONVERT: begin
          // done beats the watchdog when both land on the same cycle
          if (adc_done_i) begin
            rd_start_o   <= 1'b1;
            conv_count_o <= conv_count_o + 16'd1;
            state        <= READOUT;
          end else if (wdog == TO_LAST) begin
            timeout_o   <= 1'b1;
            read_done_o <= 1'b1;
            state       <= RELEASE;
          end else begin
            wdog <= wdog + 16'd1;
          end
        end
        READOUT: begin
          // rd_done_i is only looked at once READOUT is current, so a pulse
          // coincident with the CONVERT->READOUT edge is dropped.
          if (rd_done_i) begin
            read_done_o <= 1'b1;
            state       <= RELEASE;
          end
        end
        RELEASE: begin
          ack_o <= grant_o;
          state <= ACK;
        end
        ACK: begin
          ptr     <= (rd_buf_o == LAST_IDX) ? '0 : rd_buf_o + 1'b1;
          grant_o <= '0;
          busy_o  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lab_digitize_sched.sv
module tb_lab_digitize_sched;

  localparam int NREQ  = 4;
  localparam int IDX_W = 2;
  localparam int TO    = 64;

  logic              clk = 1'b0;
  logic              rst_i, enable_i, adc_done_i, rd_done_i, timeout_clr_i;
  logic [NREQ-1:0]   req_i;
  logic [NREQ-1:0]   ack_o, grant_o;
  logic              busy_o, adc_start_o, read_done_o, rd_start_o, timeout_o;
  logic [IDX_W-1:0]  rd_buf_o;
  logic [15:0]       conv_count_o;

  lab_digitize_sched #(.NREQ(NREQ), .IDX_W(IDX_W), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .req_i(req_i),
    .ack_o(ack_o), .grant_o(grant_o), .busy_o(busy_o),
    .adc_start_o(adc_start_o), .adc_done_i(adc_done_i),
    .read_done_o(read_done_o), .rd_start_o(rd_start_o), .rd_buf_o(rd_buf_o),
    .rd_done_i(rd_done_i), .timeout_o(timeout_o),
    .timeout_clr_i(timeout_clr_i), .conv_count_o(conv_count_o)
  );

  always #5 clk = ~clk;

  // expected completion of one transaction
  typedef struct {
    int          idx;
    logic        tmo;
    logic [15:0] cnt;
  } exp_t;

  // how the ADC / readout side behaves for one transaction
  typedef struct {
    bit tmo;
    int dly;
    int rdly;
    bit spur;
    bit drop;
  } plan_t;

  exp_t  exp_q[$];
  int    rd_q[$];
  plan_t plan_q[$];

  int          n_checks = 0;
  int          n_pass   = 0;
  int          rdn      = 0;
  int          ptr_m    = 0;
  logic [15:0] cnt_m    = '0;
  logic        tmo_m    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // first pending requester at or after p, wrapping
  function automatic int next_owner(input logic [NREQ-1:0] rem, input int p);
    for (int k = 0; k < NREQ; k++)
      if (rem[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  // mode: 0 random, 1 normal fixed, 2 watchdog, 3 done on expiry, 4 long readout
  task automatic push_round(input logic [NREQ-1:0] mask, input int mode);
    logic [NREQ-1:0] rem;
    int    idx;
    plan_t p;
    exp_t  e;
    rem = mask;
    while (rem != '0) begin
      idx    = next_owner(rem, ptr_m);
      p.tmo  = 1'b0;
      p.dly  = 20;
      p.rdly = 5;
      p.spur = 1'b0;
      p.drop = 1'b0;
      case (mode)
        0: begin
          p.tmo  = ($urandom_range(0, 5) == 0);
          p.dly  = ($urandom_range(0, 7) == 0) ? TO - 1 : int'($urandom_range(0, 25));
          p.rdly = $urandom_range(0, 6);
          p.spur = $urandom_range(0, 1);
          p.drop = $urandom_range(0, 1);
        end
        2: p.tmo = 1'b1;
        3: begin p.dly = TO - 1; p.spur = 1'b1; p.rdly = 3; end
        4: begin p.dly = 2; p.rdly = 30; end
        default: ;
      endcase
      if (p.tmo) tmo_m = 1'b1;
      else begin
        cnt_m = cnt_m + 16'd1;
        rd_q.push_back(idx);
      end
      e.idx = idx;
      e.tmo = tmo_m;
      e.cnt = cnt_m;
      exp_q.push_back(e);
      plan_q.push_back(p);
      rem[idx] = 1'b0;
      ptr_m    = (idx + 1) % NREQ;
    end
  endtask

  task automatic wait_empty(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("round_done", exp_q.size(), 0);
      exp_q.delete();
      rd_q.delete();
      plan_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic clear_tmo();
    timeout_clr_i = 1'b1;
    @(negedge clk);
    timeout_clr_i = 1'b0;
    tmo_m = 1'b0;
    chk("timeout_clear", timeout_o, tmo_m);
  endtask

  // monitor / scoreboard
  initial begin
    exp_t x;
    int   r;
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        if (adc_start_o) begin
          if (exp_q.size() == 0) chk("start_unexpected", adc_start_o, 0);
          else begin
            chk("grant", grant_o, onehot(exp_q[0].idx));
            chk("busy_in_start", busy_o, 1);
          end
        end
        if (rd_start_o) begin
          if (rd_q.size() == 0) chk("rd_start_unexpected", rd_start_o, 0);
          else begin
            r = rd_q.pop_front();
            chk("rd_buf", rd_buf_o, r);
          end
        end
        if (read_done_o) rdn++;
        if (ack_o != '0) begin
          if (exp_q.size() == 0) chk("ack_unexpected", ack_o, 0);
          else begin
            x = exp_q.pop_front();
            chk("ack", ack_o, onehot(x.idx));
            chk("ack_timeout", timeout_o, x.tmo);
            chk("ack_conv_count", conv_count_o, x.cnt);
            chk("read_done_pulses", rdn, 1);
          end
          rdn = 0;
        end
      end
    end
  end

  // requesters drop their line when acked
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_i && ack_o != '0) req_i = req_i & ~ack_o;
    end
  end

  // ADC sequencer / readout responder
  initial begin
    plan_t p;
    forever begin
      @(negedge clk);
      if (!rst_i && adc_start_o && plan_q.size() != 0) begin
        p = plan_q.pop_front();
        if (p.drop) req_i = req_i & ~grant_o;
        if (!p.tmo) begin
          repeat (p.dly + 1) @(negedge clk);
          adc_done_i = 1'b1;
          rd_done_i  = p.spur;
          @(negedge clk);
          adc_done_i = 1'b0;
          rd_done_i  = 1'b0;
          repeat (p.rdly) @(negedge clk);
          rd_done_i = 1'b1;
          @(negedge clk);
          rd_done_i = 1'b0;
        end
      end
    end
  end

  // stimulus
  initial begin
    int n;
    int n0;
    logic [NREQ-1:0] m;
    rst_i = 1'b1; enable_i = 1'b1; req_i = '0;
    adc_done_i = 1'b0; rd_done_i = 1'b0; timeout_clr_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {ack_o, grant_o, busy_o, adc_start_o, read_done_o,
                          rd_start_o, rd_buf_o, timeout_o, conv_count_o}, 0);
    rst_i = 1'b0;
    @(negedge clk);

    // single request
    push_round(4'b0001, 1);
    req_i = 4'b0001;
    wait_empty(500);
    chk("idle_busy", busy_o, 0);
    chk("idle_grant", grant_o, 0);
    chk("single_count", conv_count_o, cnt_m);

    // all four held
    push_round(4'b1111, 1);
    req_i = 4'b1111;
    wait_empty(1000);
    chk("rr_count", conv_count_o, cnt_m);

    // watchdog abort
    push_round(4'b0100, 2);
    req_i = 4'b0100;
    wait_empty(500);
    chk("timeout_sticky", timeout_o, tmo_m);
    chk("timeout_count", conv_count_o, cnt_m);
    clear_tmo();

    // done on the expiry cycle, stray rd_done_i alongside it
    push_round(4'b0010, 3);
    req_i = 4'b0010;
    wait_empty(500);
    chk("race_no_timeout", timeout_o, tmo_m);

    // grants blocked while disabled
    enable_i = 1'b0;
    req_i = 4'b0010;
    repeat (10) @(negedge clk);
    chk("disabled_grant", grant_o, 0);
    chk("disabled_busy", busy_o, 0);
    push_round(4'b0010, 0);
    enable_i = 1'b1;
    wait_empty(1000);
    if (tmo_m) clear_tmo();

    // enable dropped mid-transaction
    push_round(4'b1111, 0);
    req_i = 4'b1111;
    n = 0;
    while (!busy_o && n < 50) begin @(negedge clk); n++; end
    chk("busy_seen", busy_o, 1);
    enable_i = 1'b0;
    n0 = exp_q.size();
    n = 0;
    while (exp_q.size() == n0 && n < 1000) begin @(negedge clk); n++; end
    repeat (6) @(negedge clk);
    chk("hold_busy", busy_o, 0);
    chk("hold_grant", grant_o, 0);
    enable_i = 1'b1;
    wait_empty(2000);

    // random rounds
    for (int r = 0; r < 12; r++) begin
      if (tmo_m) clear_tmo();
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      push_round(m, 0);
      req_i = m;
      wait_empty(2000);
    end
    chk("rand_count", conv_count_o, cnt_m);
    if (tmo_m) clear_tmo();

    // reset in the middle of READOUT
    push_round(4'b0100, 4);
    req_i = 4'b0100;
    n = 0;
    while (!rd_start_o && n < 200) begin @(negedge clk); n++; end
    chk("reach_readout", rd_start_o, 1);
    rst_i = 1'b1;
    req_i = '0;
    @(negedge clk);
    chk("midreset_outputs", {ack_o, grant_o, busy_o, adc_start_o, read_done_o,
                             rd_start_o, rd_buf_o, timeout_o, conv_count_o}, 0);
    rst_i = 1'b0;
    exp_q.delete(); rd_q.delete(); plan_q.delete();
    ptr_m = 0; cnt_m = '0; tmo_m = 1'b0; rdn = 0;
    repeat (40) @(negedge clk);
    chk("no_late_ack_busy", busy_o, 0);

    // index 0 wins first after reset
    push_round(4'b1001, 1);
    req_i = 4'b1001;
    wait_empty(1000);
    chk("post_reset_count", conv_count_o, cnt_m);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
